// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and constants for the FIFO write-port arbiter.
//   - state_t : arbiter FSM states (IDLE, BURST)
//   - IDX_W   : width of a requester index. One-hot grant vectors are
//               converted to and from indices of this width, so it
//               covers the largest supported requester count (8).
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches the request vector starting
//   at the requester just after the previous owner and wrapping around.
// Ports
//   i_req     in   NUM_REQ  request vector
//   i_last    in   IDX_W    index of the previous owner
//   o_winner  out  IDX_W    index of the first set request after i_last
//   o_any_req out  1        at least one request is set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_req
);

  int w_best;
  int w_dist;

  // Each requester's distance from the previous owner is its position in
  // the circular search order; the smallest distance with a request wins.
  always_comb begin
    o_winner = '0;
    w_best   = NUM_REQ;
    w_dist   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_dist = (k + 2 * NUM_REQ - int'(i_last) - 1) % NUM_REQ;
      if (i_req[k] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_winner = IDX_W'(k);
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of async_fifo among NUM_REQ producers in the
//   write clock domain. Round-robin arbitration, bursts of at most BURST_LEN
//   words per grant, writes gated by full_i so the FIFO is never written
//   while full.
// Ports
//   clk_i    in   1              write-side clock (FIFO wr_clk_i)
//   rst_i    in   1              asynchronous active-high reset
//   req_i    in   NUM_REQ        per-requester level request
//   wdata_i  in   NUM_REQ*WIDTH  packed producer data, requester k at [k*WIDTH +: WIDTH]
//   ack_o    out  NUM_REQ        one-hot, word from requester k accepted this cycle
//   gnt_o    out  NUM_REQ        registered one-hot grant, 0 when idle
//   wr_en_o  out  1              FIFO write enable
//   wdata_o  out  WIDTH          FIFO write data
//   full_i   in   1              FIFO full flag
//   busy_o   out  1              high while a burst is in progress
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     wr_en_o,
  output logic [WIDTH-1:0]         wdata_o,
  input  logic                     full_i,
  output logic                     busy_o
);

  localparam int                CW        = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0]     LAST_CNT  = CW'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  RST_OWNER = IDX_W'(NUM_REQ - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [IDX_W-1:0]     r_last_owner;
  logic [CW-1:0]        r_count;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_any_req;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic                 w_owner_req;
  logic                 w_accept;
  logic                 w_burst_done;
  logic                 w_release;
  logic [WIDTH-1:0]     w_gnt_data [NUM_REQ];
  logic [WIDTH-1:0]     w_mux_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req     (req_i),
    .i_last    (r_last_owner),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  // Index-to-one-hot for the new grant, and per-requester data masked by
  // the current grant so the data mux reduces to an OR.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_win_onehot[gi] = (w_winner == IDX_W'(gi));
      assign w_gnt_data[gi]   = r_gnt[gi] ? wdata_i[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    w_mux_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_mux_data = w_mux_data | w_gnt_data[k];
    end
  end

  // The grant is one-hot on the owner, so masking req_i with it selects
  // the owner's request. full_i enters the accept term combinationally so
  // a write is blocked in the very cycle the FIFO reports full.
  assign w_owner_req  = |(req_i & r_gnt);
  assign w_accept     = (r_state == ST_BURST) && w_owner_req && !full_i;
  assign w_burst_done = w_accept && (r_count == LAST_CNT);
  assign w_release    = (r_state == ST_BURST) && (!w_owner_req || w_burst_done);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_release) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Grant, previous owner and burst counter. Full stalls leave the
  // counter untouched, so only accepted words count toward the burst.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gnt        <= '0;
      r_last_owner <= RST_OWNER;
      r_count      <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_req) begin
        r_gnt        <= w_win_onehot;
        r_last_owner <= w_winner;
        r_count      <= '0;
      end
    end else if (w_release) begin
      r_gnt   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

  // FSM outputs
  always_comb begin
    wr_en_o = w_accept;
    ack_o   = w_accept ? r_gnt : '0;
    wdata_o = w_accept ? w_mux_data : '0;
    busy_o  = (r_state == ST_BURST);
  end

  assign gnt_o = r_gnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int BL    = 4;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   wdata_i;
  logic [N-1:0]     ack_o;
  logic [N-1:0]     gnt_o;
  logic             wr_en_o;
  logic [W-1:0]     wdata_o;
  logic             full_i;
  logic             busy_o;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .WIDTH     (W),
    .BURST_LEN (BL)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .wdata_i (wdata_i),
    .ack_o   (ack_o),
    .gnt_o   (gnt_o),
    .wr_en_o (wr_en_o),
    .wdata_o (wdata_o),
    .full_i  (full_i),
    .busy_o  (busy_o)
  );

  int total = 0;
  int bad   = 0;
  int wr_err = 0;

  // producer words currently presented
  logic [W-1:0] cur_word [N];
  // behavioural FIFO contents, words read out, words the model says were accepted
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] rd_log[$];
  logic [W-1:0] exp_log[$];

  // reference model: who owns the write port and how many words it has sent
  bit m_busy;
  int m_owner;
  int m_last;
  int m_cnt;

  logic [N-1:0] exp_ack, exp_gnt;
  logic         exp_wr, exp_busy;
  logic [W-1:0] exp_data;
  logic         s_wr;
  logic [W-1:0] s_data;

  function automatic logic [17:0] obs_vec();
    return {ack_o, gnt_o, wr_en_o, wdata_o, busy_o};
  endfunction

  function automatic logic [17:0] exp_vec();
    return {exp_ack, exp_gnt, exp_wr, exp_data, exp_busy};
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_last  = N - 1;
    m_cnt   = 0;
    fifo_q.delete();
    rd_log.delete();
    exp_log.delete();
  endtask

  // Drive one cycle's inputs just after the edge, then at the falling edge
  // work out what the outputs must be.
  task automatic settle(input logic [N-1:0] req);
    req_i = req;
    for (int k = 0; k < N; k++) wdata_i[k*W +: W] = cur_word[k];
    full_i = (fifo_q.size() >= DEPTH);
    #4;
    exp_busy = m_busy;
    exp_gnt  = '0;
    exp_ack  = '0;
    exp_data = '0;
    if (m_busy) exp_gnt[m_owner] = 1'b1;
    exp_wr = m_busy && req[m_owner] && !full_i;
    if (exp_wr) begin
      exp_ack[m_owner] = 1'b1;
      exp_data = cur_word[m_owner];
    end
  endtask

  // Take the clock edge: FIFO read/write, model update, producers advance.
  task automatic advance(input bit rd);
    logic [N-1:0] req;
    bit           found;
    int           k;
    req    = req_i;
    s_wr   = wr_en_o;
    s_data = wdata_o;
    if (wr_en_o && full_i) wr_err++;
    @(posedge clk);
    if (rd && fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
    if (s_wr) fifo_q.push_back(s_data);
    if (!m_busy) begin
      found = 0;
      for (int off = 1; off <= N; off++) begin
        k = (m_last + off) % N;
        if (!found && req[k]) begin
          found   = 1;
          m_owner = k;
          m_last  = k;
          m_busy  = 1;
          m_cnt   = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 0;
      m_cnt  = 0;
    end else if (exp_wr) begin
      exp_log.push_back(exp_data);
      if (m_cnt == BL - 1) begin
        m_busy = 0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
    for (int j = 0; j < N; j++) if (exp_ack[j]) cur_word[j] = W'($urandom);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i  = 1'b1;
    req_i  = 4'b1111;
    full_i = 1'b0;
    #20;
    total++;
    if (gnt_o !== 4'b0000) begin
      bad++; $display("FAIL reset_gnt got=%b want=0000", gnt_o);
    end
    total++;
    if ({wr_en_o, ack_o, busy_o, wdata_o} !== '0) begin
      bad++; $display("FAIL reset_outs wr=%b ack=%b busy=%b data=%h want all 0", wr_en_o, ack_o, busy_o, wdata_o);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle(4'b1111);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        total++;
        if (gnt_o !== 4'b0001) begin
          bad++; $display("FAIL reset_first_gnt got=%b want=0001", gnt_o);
        end
      end
      advance(1'b0);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] grants[$];
    logic [N-1:0] prev;
    logic [N-1:0] want_seq [5];
    int           acks [6];
    int           idles;
    int           mism;
    want_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    prev  = '0;
    idles = 0;
    for (int i = 0; i < 6; i++) acks[i] = 0;
    for (int c = 0; c < 22; c++) begin
      settle(4'b1111);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL rr_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (gnt_o != 0 && gnt_o != prev) grants.push_back(gnt_o);
      if (gnt_o == 0 && grants.size() > 0) idles++;
      if (|ack_o && grants.size() > 0 && grants.size() <= 5) acks[grants.size()-1]++;
      prev = gnt_o;
      advance(1'b0);
    end
    total++;
    if (grants.size() != 5) begin
      bad++; $display("FAIL rr_grant_count got=%0d want=5", grants.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (grants[i] !== want_seq[i]) begin
          bad++; $display("FAIL rr_grant%0d got=%b want=%b", i, grants[i], want_seq[i]);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acks[i] != BL) begin
        bad++; $display("FAIL rr_acks%0d got=%0d want=%0d", i, acks[i], BL);
      end
    end
    total++;
    if (idles != 4) begin
      bad++; $display("FAIL rr_idle_cycles got=%0d want=4", idles);
    end
    total++;
    if (fifo_q.size() != 16 || exp_log.size() != 16) begin
      bad++; $display("FAIL rr_words got=%0d want=16 (model %0d)", fifo_q.size(), exp_log.size());
    end else begin
      mism = 0;
      for (int i = 0; i < 16; i++) if (fifo_q[i] !== exp_log[i]) mism++;
      total++;
      if (mism != 0) begin
        bad++; $display("FAIL rr_order got=%0d wrong words want=0", mism);
      end
    end
  endtask

  task automatic test_early_release();
    int acks;
    logic [N-1:0] r;
    do_reset();
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      r = (acks < 2) ? 4'b0001 : 4'b0000;
      settle(r);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL early_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (exp_ack[0]) acks++;
      advance(1'b0);
    end
    total++;
    if (fifo_q.size() != 2 || busy_o !== 1'b0) begin
      bad++; $display("FAIL early_words got=%0d busy=%b want=2 busy=0", fifo_q.size(), busy_o);
    end
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      settle(4'b0100);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL early_req2_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        total++;
        if (gnt_o !== 4'b0100) begin
          bad++; $display("FAIL early_req2_gnt got=%b want=0100", gnt_o);
        end
      end
      if (ack_o[2]) acks++;
      advance(1'b0);
    end
    total++;
    if (acks != BL) begin
      bad++; $display("FAIL early_req2_acks got=%0d want=%0d", acks, BL);
    end
  endtask

  task automatic test_full();
    int writes;
    do_reset();
    for (int i = 0; i < DEPTH; i++) fifo_q.push_back(W'($urandom));
    writes = 0;
    wr_err = 0;
    for (int c = 0; c < 8; c++) begin
      settle(4'b0010);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (wr_en_o) writes++;
      advance(1'b0);
    end
    total++;
    if (writes != 0 || gnt_o !== 4'b0010) begin
      bad++; $display("FAIL full_hold writes=%0d gnt=%b want writes=0 gnt=0010", writes, gnt_o);
    end
    for (int c = 0; c < 10; c++) begin
      settle(4'b0010);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL full_drain_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (wr_en_o) writes++;
      advance(c == 0 || c == 4);
    end
    total++;
    if (writes != 2) begin
      bad++; $display("FAIL full_after_read writes=%0d want=2", writes);
    end
    total++;
    if (wr_err != 0) begin
      bad++; $display("FAIL full_wr_error got=%0d want=0", wr_err);
    end
  endtask

  task automatic test_mid_reset();
    int  acks;
    bit  hit;
    do_reset();
    acks = 0;
    hit  = 0;
    for (int c = 0; c < 10 && !hit; c++) begin
      settle(4'b0010);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL midrst_cycle%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (exp_ack != 0) acks++;
      if (acks == 2) hit = 1;
      else advance(1'b0);
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL midrst_timeout acks=%0d want=2", acks);
    end
    rst_i = 1'b1;
    #1;
    total++;
    if ({wr_en_o, ack_o, gnt_o, busy_o, wdata_o} !== '0) begin
      bad++; $display("FAIL midrst_outs wr=%b ack=%b gnt=%b busy=%b data=%h want all 0", wr_en_o, ack_o, gnt_o, busy_o, wdata_o);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle(4'b1111);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL midrst_restart%0d got=%h want=%h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        total++;
        if (gnt_o !== 4'b0001) begin
          bad++; $display("FAIL midrst_first_gnt got=%b want=0001", gnt_o);
        end
      end
      advance(1'b0);
    end
  endtask

  task automatic test_data_integrity();
    int           rem [N];
    logic [N-1:0] r;
    int           cyc;
    int           mism;
    bit           rd;
    do_reset();
    wr_err = 0;
    for (int k = 0; k < N; k++) rem[k] = 16;
    cyc = 0;
    while ((exp_log.size() < 64 || fifo_q.size() > 0) && cyc < 4000) begin
      for (int k = 0; k < N; k++) r[k] = (rem[k] > 0) && ($urandom_range(7) != 0);
      rd = (exp_log.size() >= 64) || ($urandom_range(2) == 0);
      settle(r);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL data_cycle%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      advance(rd);
      for (int k = 0; k < N; k++) if (exp_ack[k]) rem[k]--;
      cyc++;
    end
    total++;
    if (cyc >= 4000) begin
      bad++; $display("FAIL data_timeout cycles=%0d accepted=%0d want 64 drained", cyc, exp_log.size());
    end
    total++;
    if (rd_log.size() != 64 || exp_log.size() != 64) begin
      bad++; $display("FAIL data_count read=%0d model=%0d want=64", rd_log.size(), exp_log.size());
    end else begin
      mism = 0;
      for (int i = 0; i < 64; i++) if (rd_log[i] !== exp_log[i]) mism++;
      total++;
      if (mism != 0) begin
        bad++; $display("FAIL data_order got=%0d wrong words want=0", mism);
      end
    end
    total++;
    if (wr_err != 0) begin
      bad++; $display("FAIL data_wr_error got=%0d want=0", wr_err);
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    req_i   = '0;
    full_i  = 1'b0;
    wdata_i = '0;
    for (int k = 0; k < N; k++) cur_word[k] = W'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_round_robin();
    test_early_release();
    test_full();
    test_mid_reset();
    test_data_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
